// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, little-endian program over a byte stream and
// writes it word by word to memory. Define LOADER_CHECKSUM_EN to require a trailing sum byte.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_di,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int KW = $clog2(MAX_WORDS + 1);

  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd2;
  localparam logic [2:0] S_END  = S_CSUM;
`else
  localparam logic [2:0] S_END  = S_DONE;
`endif

  logic [2:0]    state;
  logic [1:0]    byte_cnt;
  logic [23:0]   asm_q;     // lanes 0..2 of the header or the payload word in flight
  logic [KW-1:0] n_words;
  logic [KW-1:0] word_idx;
  logic [31:0]   full_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  // Lane 3 arrives on rx_data itself, so the complete word is available in the same cycle.
  assign full_word = {rx_data, asm_q};

`ifdef LOADER_CHECKSUM_EN
  assign busy = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
`else
  assign busy = (state == S_HDR) || (state == S_DATA);
`endif
  assign done = (state == S_DONE);
  assign err  = (state == S_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_HDR;
      byte_cnt   <= 2'd0;
      asm_q      <= 24'd0;
      n_words    <= '0;
      word_idx   <= '0;
      mem_we     <= 4'h0;
      mem_addr   <= 32'd0;
      mem_di     <= 32'd0;
      core_rst_n <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= 8'd0;
`endif
    end else begin
      mem_we     <= 4'h0;
      core_rst_n <= (state == S_DONE);

      if (rx_valid && ((state == S_HDR) || (state == S_DATA))) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    asm_q[7:0]   <= rx_data;
          2'd1:    asm_q[15:8]  <= rx_data;
          2'd2:    asm_q[23:16] <= rx_data;
          default: asm_q        <= 24'd0;
        endcase
      end

      if (rx_valid) begin
        case (state)
          S_HDR: begin
            if (byte_cnt == 2'd3) begin
              if (full_word == 32'd0) begin
                state <= S_END;
              end else if (full_word > 32'(MAX_WORDS)) begin
                state <= S_ERR;
              end else begin
                n_words  <= full_word[KW-1:0];
                word_idx <= '0;
                state    <= S_DATA;
              end
            end
          end
          S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
            sum <= sum + rx_data;
`endif
            if (byte_cnt == 2'd3) begin
              mem_we   <= 4'hF;
              mem_addr <= BASE_ADDR + (32'(word_idx) << 2);
              mem_di   <= full_word;
              word_idx <= word_idx + 1'b1;
              if (word_idx == n_words - 1'b1) begin
                state <= S_END;
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          S_CSUM: begin
            state <= (sum == rx_data) ? S_DONE : S_ERR;
          end
`endif
          default: begin
            // DONE and ERR hold until reset.
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table vectors, hand-written corner sequences and random streams,
// all checked against a stream-parsing model of the load format.
`timescale 1ns/1ps
module tb_prog_loader;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  stream_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic [3:0]  exp_status;   // {busy, done, err, core_rst_n}

  typedef struct {
    logic [31:0] n;
    int          words;
    int          max_gap;
    bit          good_csum;
    logic        exp_done;
    logic        exp_err;
    int          exp_writes;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Every write seen on the memory port must be a full-word strobe.
  always @(negedge clk) begin
    if (rst_n && mem_we !== 4'h0) begin
      check("mem_we", 64'(mem_we), 64'hF);
      got_q.push_back({mem_addr, mem_di});
    end
  end

  // Parses the byte stream the way the format defines it; trailing bytes after a
  // terminal outcome are simply never read.
  task automatic model_build();
    int          nb;
    logic [31:0] n;
    logic [31:0] w;
    logic [7:0]  s;
    nb = stream_q.size();
    s = 8'd0;
    exp_q.delete();
    exp_status = 4'b1000;
    if (nb < 4) return;
    n = {stream_q[3], stream_q[2], stream_q[1], stream_q[0]};
    if (n > 32'(MAXW)) begin
      exp_status = 4'b0010;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      if (4 * i + 7 >= nb) return;
      w = {stream_q[4*i+7], stream_q[4*i+6], stream_q[4*i+5], stream_q[4*i+4]};
      for (int b = 4; b < 8; b++) s = s + stream_q[4*i+b];
      exp_q.push_back({BASE + 32'(4 * i), w});
    end
`ifdef LOADER_CHECKSUM_EN
    if (nb <= 4 + 4 * int'(n)) return;
    exp_status = (stream_q[4 + 4 * int'(n)] == s) ? 4'b0101 : 4'b0010;
`else
    exp_status = 4'b0101;
`endif
  endtask

  task automatic make_stream(input logic [31:0] n, input int words, input bit good_csum);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'd0;
    stream_q.delete();
    for (int i = 0; i < 4; i++) stream_q.push_back(n[8*i +: 8]);
    for (int i = 0; i < 4 * words; i++) begin
      b = 8'($urandom_range(0, 255));
      s = s + b;
      stream_q.push_back(b);
    end
`ifdef LOADER_CHECKSUM_EN
    stream_q.push_back(good_csum ? s : s + 8'd1);
`else
    if (good_csum) s = s;
`endif
  endtask

  // Entered and left at 1ns after a rising edge; no gap after the last byte.
  task automatic send_stream(input int max_gap);
    for (int i = 0; i < stream_q.size(); i++) begin
      rx_data  = stream_q[i];
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      if (i != stream_q.size() - 1) begin
        repeat ($urandom_range(0, max_gap)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic do_reset(input string name);
    rx_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check({name, ":rst_we"}, 64'(mem_we), 64'h0);
    check({name, ":rst_addr_di"}, {mem_addr, mem_di}, 64'h0);
    check({name, ":rst_status"}, 64'({busy, done, err, core_rst_n}), 64'b1000);
    got_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_result(input string name);
    repeat (3) @(negedge clk);
    model_build();
    check({name, ":nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, ":write"}, got_q[i], exp_q[i]);
    check({name, ":status"}, 64'({busy, done, err, core_rst_n}), 64'(exp_status));
  endtask

  initial begin
    tbl[0] = '{32'd2,          2,    0, 1'b1, 1'b1, 1'b0, 2};
    tbl[1] = '{32'd0,          0,    2, 1'b1, 1'b1, 1'b0, 0};
    tbl[2] = '{32'd1025,       2,    1, 1'b1, 1'b0, 1'b1, 0};
    tbl[3] = '{32'd1024,       1024, 0, 1'b1, 1'b1, 1'b0, 1024};
    tbl[4] = '{32'd5,          5,    4, 1'b1, 1'b1, 1'b0, 5};
    tbl[5] = '{32'h0100_0001,  1,    0, 1'b1, 1'b0, 1'b1, 0};
`ifdef LOADER_CHECKSUM_EN
    tbl[6] = '{32'd3,          3,    2, 1'b0, 1'b0, 1'b1, 3};
`else
    tbl[6] = '{32'd3,          3,    2, 1'b0, 1'b1, 1'b0, 3};
`endif

    do_reset("init");

    // Reference program; core reset releases one cycle after DONE.
    stream_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    stream_q.push_back(8'hB6);
`endif
    send_stream(3);
    @(negedge clk);
    check("ref:done_edge", 64'({done, core_rst_n}), 64'b10);
    @(negedge clk);
    check("ref:core_rst_edge", 64'({done, core_rst_n}), 64'b11);
    check_result("ref");
    if (got_q.size() == 2) begin
      check("ref:word0", got_q[0], {BASE, 32'h0000_0013});
      check("ref:word1", got_q[1], {BASE + 32'd4, 32'h0010_0093});
    end
    // DONE is terminal: further bytes are ignored.
    for (int i = 0; i < 8; i++) stream_q.push_back(8'($urandom_range(0, 255)));
    send_stream(0);
    check_result("done_terminal");

`ifdef LOADER_CHECKSUM_EN
    do_reset("bad_csum");
    stream_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
    send_stream(1);
    check_result("bad_csum");
    check("bad_csum:err", 64'({err, core_rst_n}), 64'b10);
`endif

    for (int v = 0; v < 7; v++) begin
      do_reset($sformatf("tbl%0d", v));
      make_stream(tbl[v].n, tbl[v].words, tbl[v].good_csum);
      send_stream(tbl[v].max_gap);
      check_result($sformatf("tbl%0d", v));
      check($sformatf("tbl%0d:done_err", v), 64'({done, err}), 64'({tbl[v].exp_done, tbl[v].exp_err}));
      check($sformatf("tbl%0d:count", v), 64'(got_q.size()), 64'(tbl[v].exp_writes));
    end

    // Reset after 6 of 8 payload bytes, then a fresh one-word program.
    do_reset("partial");
    make_stream(32'd2, 2, 1'b1);
    while (stream_q.size() > 10) void'(stream_q.pop_back());
    send_stream(1);
    check_result("partial");
    do_reset("restart");
    stream_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    stream_q.push_back(8'h37);
`endif
    send_stream(0);
    check_result("restart");
    if (got_q.size() == 1) check("restart:word", got_q[0], {BASE, 32'h0000_0037});

    for (int r = 0; r < 20; r++) begin
      int n;
      do_reset($sformatf("rnd%0d", r));
      n = $urandom_range(1, 8);
      make_stream(32'(n), n, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        int cut;
        cut = $urandom_range(1, stream_q.size());
        while (stream_q.size() > cut) void'(stream_q.pop_back());
      end
      send_stream($urandom_range(0, 3));
      check_result($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first program word written to instruction/data memory.
REQ-002 Parameter MAX_WORDS, default 1024, largest accepted program length in 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rx_data  input  8  received byte from the serial receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid and is consumed this cycle.
REQ-007 mem_we  output  4  byte-lane write enables to memory port A.
REQ-008 mem_addr  output  32  byte address for the write, word aligned.
REQ-009 mem_di  output  32  write data.
REQ-010 core_rst_n  output  1  active-low reset to the pipelined core; low until the load completes successfully.
REQ-011 busy  output  1  high while the block is in HDR, DATA or CSUM.
REQ-012 done  output  1  high in DONE.
REQ-013 err  output  1  high in ERR.

Function
REQ-014 The stream format SHALL be a 4-byte little-endian word count N, then N words of 4 little-endian bytes each, then (LOADER_CHECKSUM_EN only) one checksum byte.
REQ-015 The FSM SHALL have states HDR, DATA, CSUM, DONE and ERR, and SHALL leave reset in HDR.
REQ-016 HDR: collect 4 bytes; on the 4th byte, N==0 goes to CSUM (macro defined) or DONE (macro undefined), N>MAX_WORDS goes to ERR, and any other N goes to DATA.
REQ-017 DATA: a 2-bit byte counter SHALL place bytes into lanes 0..3; on lane 3, exactly one write SHALL be issued.
REQ-018 Write timing: mem_we==4'hF, mem_addr==BASE_ADDR+4*k and mem_di==assembled word k SHALL all be registered and asserted for exactly one cycle, the cycle after the 4th byte's rx_valid.
REQ-019 mem_we SHALL be 4'h0 in every other cycle.
REQ-020 After word N-1 is written, the FSM SHALL go to CSUM (macro defined) or DONE.
REQ-021 Bytes per cycle: at most one byte is consumed per cycle; back-to-back rx_valid on consecutive cycles SHALL be accepted without loss.
REQ-022 The word index k SHALL be wide enough for MAX_WORDS; mem_addr SHALL wrap modulo 2^32.
REQ-023 DONE and ERR are terminal: rx_valid SHALL be ignored and no writes SHALL be issued until rst_n is asserted.
REQ-024 core_rst_n SHALL go high on the cycle after DONE is entered and stay high in DONE; it SHALL be low in every other state.
REQ-025 Gaps of any length between rx_valid strobes SHALL NOT alter state; there is no timeout.

Reset
REQ-026 On rst_n low, asynchronously: state=HDR, all counters and assembly registers=0, mem_we=4'h0, mem_addr=0, mem_di=0, core_rst_n=0, busy=1, done=0, err=0.
REQ-027 Reset mid-operation SHALL abandon the partial load; the next stream restarts from the header and no partial word is written.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: the 8-bit modulo-256 sum of all 4N payload bytes (header excluded) SHALL be compared with the trailing byte in CSUM; a match goes to DONE, a mismatch goes to ERR.
REQ-029 Macro LOADER_CHECKSUM_EN undefined: the CSUM state and the sum register SHALL be absent, and the last payload word goes directly to DONE.

Verification
REQ-030 N=2, payload 13 00 00 00 93 00 10 00 -> writes (addr 0, 32'h0000_0013) then (addr 4, 32'h0010_0093); with the macro undefined, core_rst_n rises 1 cycle after DONE.
REQ-031 Macro defined, same payload plus checksum 8'hB6 -> DONE and core_rst_n=1; the same stream with checksum 8'hB7 -> ERR, err=1, core_rst_n stays 0.
REQ-032 Header N=MAX_WORDS+1 (1025) -> ERR after the 4th header byte, with zero writes.
REQ-033 Header N=0 -> DONE (macro undefined) with no writes.
REQ-034 rst_n pulsed low after 6 of 8 payload bytes, then a full N=1 stream 37 00 00 00 -> only one write: addr 0, data 32'h0000_0037.
REQ-035 rx_valid held high for 12 consecutive cycles (N=2, BASE_ADDR=32'h100) -> writes at 32'h100 and 32'h104, each a single-cycle mem_we=4'hF, with no dropped bytes.
